approx_err_monitor: RTL and testbench

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_err_monitor.sv | 102 ++++++++++
 tb/tb_approx_err_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: measures error statistics of an approximate adder over a run of samples
module approx_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   IN1,
  input  logic [WIDTH-1:0]   IN2,
  input  logic [WIDTH:0]     approx_sum,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   sample_count,
  output logic [ACC_W-1:0]   abs_err_sum,
  output logic [WIDTH:0]     max_abs_err,
  output logic [WIDTH-1:0]   worst_IN1,
  output logic [WIDTH-1:0]   worst_IN2
);
  // sum width wide enough for either operand plus a carry, so saturation is detected for any ACC_W
  localparam int SW = (ACC_W > WIDTH + 1 ? ACC_W : WIDTH + 1) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] target, accepted;
  logic drain_cnt, hs, go, s1_v;
  logic [WIDTH:0] exact, abs_err, s1_err;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [SW-1:0] sum_w;
  assign go = start && (state == IDLE || state == DONE);
  assign hs = in_valid && in_ready;
  assign exact = {1'b0, IN1} + {1'b0, IN2};
  assign abs_err = exact >= approx_sum ? exact - approx_sum : approx_sum - exact;
  assign sum_w = SW'(abs_err_sum) + SW'(s1_err);
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: start wins in IDLE/DONE, final handshake drains, two drain cycles empty the pipeline
  always_comb begin
    state_nx = go ? (num_samples == '0 ? DONE : RUN)
             : (state == RUN && hs && accepted + CNT_W'(1) == target) ? DRAIN
             : (state == DRAIN && drain_cnt) ? DONE : state;
  end
  // status outputs decoded from state
  always_comb begin
    in_ready = state == RUN && accepted < target;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  // run length capture, handshake counting and drain timing
  always_ff @(posedge clk)
    if (rst) begin
      target <= '0;
      accepted <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (go) begin
        target <= num_samples;
        accepted <= '0;
      end else if (hs) accepted <= accepted + CNT_W'(1);
      drain_cnt <= state == DRAIN ? ~drain_cnt : 1'b0;
    end
  // stage 1: register the absolute error and operands of each accepted sample
  always_ff @(posedge clk)
    if (rst) begin
      s1_v <= 1'b0;
      s1_err <= '0;
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_v <= hs;
      if (hs) begin
        s1_err <= abs_err;
        s1_a <= IN1;
        s1_b <= IN2;
      end
    end
  // stage 2: accumulate statistics; a new run clears them, ties keep the earlier worst case
  always_ff @(posedge clk)
    if (rst || go) begin
      err_count <= '0;
      sample_count <= '0;
      abs_err_sum <= '0;
      max_abs_err <= '0;
      worst_IN1 <= '0;
      worst_IN2 <= '0;
    end else if (s1_v) begin
      sample_count <= sample_count + CNT_W'(1);
      if (s1_err != '0) err_count <= err_count + CNT_W'(1);
      abs_err_sum <= sum_w > SW'({ACC_W{1'b1}}) ? '1 : sum_w[ACC_W-1:0];
      if (s1_err > max_abs_err) begin
        max_abs_err <= s1_err;
        worst_IN1 <= s1_a;
        worst_IN2 <= s1_b;
      end
    end
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed and random runs checked against a list-based error model
module tb_approx_err_monitor;
  typedef struct packed {logic [7:0] a; logic [7:0] b; logic [8:0] s;} sample_t;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [15:0] num_samples = 0;
  logic [7:0] in1 = 0, in2 = 0;
  logic [8:0] approx = 0;
  logic rdy, busy, done, rdy_s, busy_s, done_s;
  logic [15:0] ec, sc, ec_s, sc_s;
  logic [23:0] sum;
  logic [3:0] sum_s;
  logic [8:0] mx, mx_s;
  logic [7:0] w1, w2, w1_s, w2_s;
  int total = 0, bad = 0;
  sample_t src[$], acc[$];

  always #5 clk = ~clk;

  approx_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(rdy), .IN1(in1), .IN2(in2), .approx_sum(approx), .busy(busy), .done(done),
    .err_count(ec), .sample_count(sc), .abs_err_sum(sum), .max_abs_err(mx),
    .worst_IN1(w1), .worst_IN2(w2));

  approx_err_monitor #(.ACC_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(rdy_s), .IN1(in1), .IN2(in2), .approx_sum(approx), .busy(busy_s), .done(done_s),
    .err_count(ec_s), .sample_count(sc_s), .abs_err_sum(sum_s), .max_abs_err(mx_s),
    .worst_IN1(w1_s), .worst_IN2(w2_s));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int a, input int b, input int s);
    sample_t x;
    x.a = 8'(a);
    x.b = 8'(b);
    x.s = 9'(s);
    src.push_back(x);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      int a, b, s;
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      s = a + b;
      if ($urandom_range(0, 1) == 1) s = s + $urandom_range(0, 40) - 20;
      if (s < 0) s = 0;
      if (s > 511) s = 511;
      add(a, b, s);
    end
  endtask

  task automatic ctrl(input string tag, input logic r, input logic b, input logic d);
    chk({tag, ".in_ready"}, rdy, r);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
    chk({tag, ".in_ready_s"}, rdy_s, r);
    chk({tag, ".done_s"}, done_s, d);
  endtask

  task automatic check_results(input string tag);
    int n_err = 0, tot = 0, mxe = 0, wa = 0, wb = 0;
    foreach (acc[i]) begin
      int e;
      e = int'(acc[i].a) + int'(acc[i].b) - int'(acc[i].s);
      if (e < 0) e = -e;
      if (e != 0) n_err++;
      tot += e;
      if (e > mxe) begin
        mxe = e;
        wa = acc[i].a;
        wb = acc[i].b;
      end
    end
    chk({tag, ".err_count"}, ec, n_err);
    chk({tag, ".sample_count"}, sc, acc.size());
    chk({tag, ".abs_err_sum"}, sum, tot > 24'hffffff ? 24'hffffff : tot);
    chk({tag, ".max_abs_err"}, mx, mxe);
    chk({tag, ".worst_IN1"}, w1, wa);
    chk({tag, ".worst_IN2"}, w2, wb);
    chk({tag, ".err_count_s"}, ec_s, n_err);
    chk({tag, ".abs_err_sum_s"}, sum_s, tot > 15 ? 15 : tot);
    chk({tag, ".max_abs_err_s"}, mx_s, mxe);
  endtask

  task automatic start_run(input string tag);
    acc.delete();
    num_samples = 16'(src.size());
    start = 1;
    step();
    start = 0;
    if (src.size() > 0) ctrl({tag, ".start"}, 1, 1, 0);
    check_results({tag, ".cleared"});
  endtask

  // feed up to limit samples; when the whole list is fed, check drain timing and held results
  task automatic feed(input string tag, input int vprob, input bit hold, input bit poke, input int limit);
    int idx = 0, cyc = 0;
    while (idx < limit && cyc < 2000) begin
      in_valid = hold || ($urandom_range(0, 99) < vprob);
      in1 = in_valid ? src[idx].a : 8'($urandom);
      in2 = in_valid ? src[idx].b : 8'($urandom);
      approx = in_valid ? src[idx].s : 9'($urandom);
      start = poke && $urandom_range(0, 7) == 0;
      num_samples = 16'($urandom_range(0, 3));
      chk({tag, ".ready_run"}, rdy, 1);
      if (in_valid) begin
        acc.push_back(src[idx]);
        idx++;
      end
      step();
      cyc++;
    end
    start = 0;
    if (idx < limit) chk({tag, ".feed_timeout"}, idx, limit);
    if (limit < src.size()) return;
    in_valid = hold;
    ctrl({tag, ".drain1"}, 0, 1, 0);
    step();
    ctrl({tag, ".drain2"}, 0, 1, 0);
    step();
    ctrl({tag, ".done"}, 0, 0, 1);
    check_results({tag, ".final"});
    repeat (3) step();
    ctrl({tag, ".hold"}, 0, 0, 1);
    check_results({tag, ".hold"});
    in_valid = 0;
  endtask

  initial begin
    step();
    step();
    ctrl("reset", 0, 0, 0);
    check_results("reset");
    rst = 0;
    step();
    ctrl("idle", 0, 0, 0);

    src.delete();
    add(5, 3, 8); add(7, 9, 16); add(255, 1, 256);
    start_run("exact");
    feed("exact", 100, 0, 0, 3);

    src.delete();
    add(1, 1, 0); add(3, 1, 5);
    start_run("err2");
    feed("err2", 100, 0, 0, 2);

    src.delete();
    add(1, 1, 0); add(2, 2, 2); add(0, 0, 2); add(9, 9, 18);
    start_run("tie");
    feed("tie", 70, 0, 0, 4);

    src.delete();
    start_run("zero");
    ctrl("zero", 0, 0, 1);
    step();
    ctrl("zero.hold", 0, 0, 1);
    check_results("zero.hold");

    src.delete();
    add(10, 10, 16); add(0, 0, 4); add(100, 50, 146); add(200, 200, 396); add(3, 4, 11);
    start_run("sat");
    feed("sat", 100, 0, 0, 5);

    src.delete();
    add_random(4);
    start_run("rst_mid");
    feed("rst_mid", 100, 0, 0, 2);
    in_valid = 1;
    start = 1;
    rst = 1;
    step();
    rst = 0;
    start = 0;
    in_valid = 0;
    acc.delete();
    ctrl("rst_mid.after", 0, 0, 0);
    check_results("rst_mid.after");
    repeat (2) step();
    check_results("rst_mid.flushed");
    start_run("rst_mid.rerun");
    feed("rst_mid.rerun", 80, 0, 0, 4);

    src.delete();
    add_random(4);
    start_run("b2b");
    feed("b2b", 100, 1, 0, 4);

    for (int r = 0; r < 4; r++) begin
      src.delete();
      add_random($urandom_range(5, 30));
      start_run("rand");
      feed("rand", 60, 0, 1, src.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
